linear_mem: RTL
===============

Name: linear_mem

Overview:
- Byte-addressed read/write WebAssembly linear memory; the write-capable counterpart of genrom.
- Serves CPU loads on the same addr/extra/bound/data/error interface genrom presents.
- Adds a byte-serial store engine with a busy/done handshake.
- Sits beside the cpu core as the data-memory responder; genrom stays the code store.

Parameters:
- AW, 5, byte-address width; depth = 2**AW bytes; address ports carry AW+1 bits so out-of-range addresses are representable.
- DW, 8, bits per memory cell (one byte).
- EXTRA, 4, access-length field width; max access = 2**EXTRA bytes.
- INITFILE, "", hex preload file; empty string means zero-filled.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  AW+1  read start byte address.
- extra  in  EXTRA  read length minus one (bytes = extra+1).
- lower_bound  in  AW+1  lowest legal byte address, inclusive, for reads and writes.
- upper_bound  in  AW+1  highest legal byte address, inclusive, for reads and writes.
- data  out  2**EXTRA*DW  read data, little-endian.
- error  out  1  read bounds violation.
- wr_en  in  1  store request.
- wr_addr  in  AW+1  store start address.
- wr_extra  in  EXTRA  store length minus one.
- wr_data  in  2**EXTRA*DW  store data; byte i goes to wr_addr+i.
- wr_busy  out  1  store engine occupied.
- wr_done  out  1  one-cycle completion pulse.
- wr_error  out  1  valid with wr_done; store rejected.

Behaviour:
- Reset values: data=0, error=0, wr_busy=0, wr_done=0, wr_error=0, FSM=IDLE, byte counter=0. Memory contents are not cleared by reset.
- Bounds rule (shared by reads and writes), using start address A and extra E, computed at AW+2 bits so there is no wrap:
  - violation if A < lower_bound, or A+E > upper_bound, or A+E >= 2**AW.
- Read timing: addr/extra are sampled every cycle; data/error are registered with 1-cycle latency.
- Read data layout:
  - data byte i = mem[A+i] for i<=E; bytes above E are 0.
  - On violation: error=1, data=0.
  - No handshake; a new read may issue every cycle.
- Store FSM:
  - IDLE: wr_en=1 captures wr_addr, wr_extra, wr_data and runs the bounds check.
    - Violation -> DONE with wr_error=1; memory untouched.
    - Otherwise -> WRITE with counter=0.
  - WRITE: writes byte[counter] to mem[A+counter] each cycle; wr_busy=1. When counter==E -> DONE.
  - DONE: wr_done=1 for exactly one cycle (wr_error=1 if rejected); wr_busy=0; -> IDLE.
  - wr_busy is 1 in WRITE only.
- Store latency: an accepted store of E+1 bytes gives wr_done E+2 cycles after the accept edge. A rejected store gives wr_done 1 cycle after accept.
- wr_en while in WRITE or DONE is ignored; there is no queueing, and the requester must wait for wr_done.
- Read/write overlap:
  - A read is served during WRITE.
  - A byte written in the same cycle as it is read returns the old value (read-before-write).
  - Bytes committed in earlier cycles return new values.
- Reset mid-store: the FSM aborts to IDLE, bytes already written remain, and no wr_done is issued.
- E=0 store: a single WRITE cycle.
- Max store (E=2**EXTRA-1): 16 WRITE cycles at default parameters.

Optional Feature:
- Macro: LINEAR_MEM_RO_GUARD_EN.
- When defined:
  - Adds parameter RO_LIMIT (default 0).
  - Any store with wr_addr < RO_LIMIT is rejected exactly like a bounds violation (wr_error=1, no bytes written).
  - Reads are unaffected.
- When undefined: no RO_LIMIT parameter and no extra logic; the store check is bounds-only.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, WRITE=2'd1, DONE=2'd2.
  - A byte-width constant.
  - An access-length helper function (extra+1).
- One natural sub-module: mem_bounds_chk (combinational; A, E, lower, upper in; violation out).
  - Instantiated twice: read path and store accept path.
  - Reusable by genrom.

Test Plan:
- Preload mem[8..11]=01 02 03 04; read addr=8, extra=3, bounds 0..31 -> next cycle data=0x04030201, upper bytes 0, error=0.
- Store wr_addr=4, wr_extra=1, wr_data=0xBEEF -> wr_busy high 2 cycles, wr_done+wr_error=0 pulse at cycle 3. Then read addr=4, extra=1 returns 0xBEEF.
- Store wr_addr=30, wr_extra=3, upper_bound=31 -> wr_done with wr_error=1 next cycle; mem[30..31] unchanged. A read of the same range returns error=1, data=0.
- While a 4-byte store to address 16 is in WRITE:
  - Read addr=16 each cycle; byte 16+k changes only on the cycle after its write.
  - Pulse wr_en during busy -> ignored; exactly one wr_done.
- Assert reset during the 3rd cycle of an 8-byte store at address 0 -> wr_busy=0 next cycle, no wr_done, bytes 0..1 new, bytes 2..7 old.
- With LINEAR_MEM_RO_GUARD_EN and RO_LIMIT=8:
  - Store at 4 -> wr_error=1, memory unchanged.
  - Store at 8 -> succeeds.

Source files
------------

// File: rtl/linear_mem_pkg.sv
// linear_mem_pkg: shared types and helpers for the linear_mem data memory.
package linear_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} wr_state_t;
    localparam int BYTE_W = 8;
    function automatic int access_len(input int extra);
        return extra + 1;
    endfunction
endpackage

// File: rtl/linear_mem_if.sv
// linear_mem_if: load port plus byte-serial store handshake between cpu and linear_mem.
interface linear_mem_if
    import linear_mem_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = BYTE_W,
    parameter int EXTRA = 4
);
    logic [AW:0] addr, lower_bound, upper_bound, wr_addr;
    logic [EXTRA-1:0] extra, wr_extra;
    logic [(2**EXTRA)*DW-1:0] data, wr_data;
    logic error, wr_en, wr_busy, wr_done, wr_error;
    modport master (
        output addr, extra, lower_bound, upper_bound, wr_en, wr_addr, wr_extra, wr_data,
        input data, error, wr_busy, wr_done, wr_error
    );
    modport slave (
        input addr, extra, lower_bound, upper_bound, wr_en, wr_addr, wr_extra, wr_data,
        output data, error, wr_busy, wr_done, wr_error
    );
endinterface

// File: rtl/mem_bounds_chk.sv
// mem_bounds_chk: flags an access [a, a+e] outside [lower, upper] or past the memory end.
module mem_bounds_chk #(
    parameter int AW = 5,
    parameter int EXTRA = 4
) (
    input  logic [AW:0]      a,
    input  logic [EXTRA-1:0] e,
    input  logic [AW:0]      lower,
    input  logic [AW:0]      upper,
    output logic             viol
);
    logic [AW+1:0] last;
    always_comb begin
        last = {1'b0, a} + (AW+2)'(e);
        viol = a < lower || last > {1'b0, upper} || last >= (AW+2)'(2**AW);
    end
endmodule

// File: rtl/linear_mem.sv
// linear_mem: byte-addressed read/write linear memory with registered loads and a byte-serial store engine.
// Optional LINEAR_MEM_RO_GUARD_EN rejects stores starting below RO_LIMIT.
module linear_mem
    import linear_mem_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = BYTE_W,
    parameter int EXTRA = 4,
    parameter string INITFILE = ""
`ifdef LINEAR_MEM_RO_GUARD_EN
    , parameter int RO_LIMIT = 0
`endif
) (
    input logic clk,
    input logic reset,
    linear_mem_if.slave bus
);
    localparam int NB = 2**EXTRA;
    logic [DW-1:0] mem [2**AW];
    logic rd_viol, st_viol, st_rej;
    logic [NB*DW-1:0] rd_next, w_data;
    logic [AW:0] w_addr;
    logic [EXTRA-1:0] w_extra, cnt;
    wr_state_t state;
    mem_bounds_chk #(.AW(AW), .EXTRA(EXTRA)) u_rd_chk (
        .a(bus.addr), .e(bus.extra), .lower(bus.lower_bound), .upper(bus.upper_bound), .viol(rd_viol)
    );
    mem_bounds_chk #(.AW(AW), .EXTRA(EXTRA)) u_wr_chk (
        .a(bus.wr_addr), .e(bus.wr_extra), .lower(bus.lower_bound), .upper(bus.upper_bound), .viol(st_viol)
    );
`ifdef LINEAR_MEM_RO_GUARD_EN
    assign st_rej = st_viol || bus.wr_addr < (AW+1)'(RO_LIMIT);
`else
    assign st_rej = st_viol;
`endif
    always_comb begin
        for (int i = 0; i < NB; i++)
            rd_next[i*DW +: DW] = i < access_len(int'(bus.extra)) ? mem[AW'(int'(bus.addr) + i)] : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data  <= '0;
            bus.error <= 1'b0;
        end else begin
            bus.data  <= rd_viol ? '0 : rd_next;
            bus.error <= rd_viol;
        end
    end
    // Gated by reset so an aborted store leaves only the bytes committed before the abort.
    always_ff @(posedge clk) begin
        if (!reset && state == WRITE)
            mem[AW'(w_addr + (AW+1)'(cnt))] <= w_data[int'(cnt)*DW +: DW];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.wr_busy  <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.wr_error <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.wr_en) begin
                    w_addr       <= bus.wr_addr;
                    w_extra      <= bus.wr_extra;
                    w_data       <= bus.wr_data;
                    cnt          <= '0;
                    state        <= st_rej ? DONE : WRITE;
                    bus.wr_busy  <= !st_rej;
                    bus.wr_done  <= st_rej;
                    bus.wr_error <= st_rej;
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == w_extra) begin
                        state       <= DONE;
                        bus.wr_busy <= 1'b0;
                        bus.wr_done <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.wr_done  <= 1'b0;
                    bus.wr_error <= 1'b0;
                end
            endcase
        end
    end
endmodule
